// File: rtl/user_mgr_arbiter.sv
// user_mgr_arbiter: round-robin OBI manager arbiter with in-order response routing.
module user_mgr_arbiter #(
  parameter int NumReq    = 2,
  parameter int MaxTrans  = 2,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_i,
  output logic [NumReq-1:0]                    gnt_o,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 err_o,
  output logic                                 mgr_req_o,
  input  logic                                 mgr_gnt_i,
  output logic [AddrWidth-1:0]                 mgr_addr_o,
  output logic                                 mgr_we_o,
  output logic [DataWidth/8-1:0]               mgr_be_o,
  output logic [DataWidth-1:0]                 mgr_wdata_o,
  input  logic                                 mgr_rvalid_i,
  input  logic [DataWidth-1:0]                 mgr_rdata_i,
  input  logic                                 mgr_err_i,
  output logic                                 idle_o,
  output logic                                 rsp_err_o
);
  localparam int IdxW = $clog2(NumReq);
  localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int CntW = $clog2(MaxTrans + 1);

  if (NumReq < 2 || MaxTrans < 1) begin : g_bad_params
    $error("user_mgr_arbiter: NumReq must be >= 2 and MaxTrans >= 1");
  end

  logic [IdxW-1:0] r_prio, r_lock_idx, w_rr_idx, w_sel;
  logic            r_lock, r_rsp_err, w_full, w_hs, w_pop;
  logic [IdxW-1:0] r_fifo [MaxTrans];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;

  // Walk downward so the requester closest to r_prio is the last (winning) assignment.
  always_comb begin
    w_rr_idx = '0;
    for (int i = NumReq - 1; i >= 0; i--)
      if (req_i[(int'(r_prio) + i) % NumReq]) w_rr_idx = IdxW'((int'(r_prio) + i) % NumReq);
  end

  assign w_sel       = r_lock ? r_lock_idx : w_rr_idx;
  assign w_full      = r_cnt == CntW'(MaxTrans);
  assign mgr_req_o   = !rst_i && !w_full && req_i[w_sel];
  assign w_hs        = mgr_req_o && mgr_gnt_i;
  assign w_pop       = !rst_i && mgr_rvalid_i && r_cnt != '0;
  assign gnt_o       = NumReq'(w_hs) << w_sel;
  assign rvalid_o    = NumReq'(w_pop) << r_fifo[r_rptr];
  assign mgr_addr_o  = addr_i[w_sel];
  assign mgr_we_o    = we_i[w_sel];
  assign mgr_be_o    = be_i[w_sel];
  assign mgr_wdata_o = wdata_i[w_sel];
  assign rdata_o     = mgr_rdata_i;
  assign err_o       = mgr_err_i;
  assign idle_o      = !(|req_i) && r_cnt == '0;
  assign rsp_err_o   = r_rsp_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_prio     <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_lock     <= mgr_req_o && !mgr_gnt_i;
      r_lock_idx <= w_sel;
      if (w_hs) begin
        r_prio <= (w_sel == IdxW'(NumReq - 1)) ? '0 : w_sel + 1'b1;
        r_wptr <= (r_wptr == PtrW'(MaxTrans - 1)) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= (r_rptr == PtrW'(MaxTrans - 1)) ? '0 : r_rptr + 1'b1;
      r_cnt <= r_cnt + CntW'(w_hs) - CntW'(w_pop);
      if (mgr_rvalid_i && r_cnt == '0) r_rsp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk_i)
    if (w_hs) r_fifo[r_wptr] <= w_sel;
endmodule

// File: tb/tb_user_mgr_arbiter.sv
// tb_user_mgr_arbiter: directed checks of arbitration, locking, FIFO limits and reset.
module tb_user_mgr_arbiter;
  logic              clk_i = 0, rst_i = 1;
  logic [1:0]        req_i = 0, gnt_o, we_i = 0, rvalid_o;
  logic [1:0][31:0]  addr_i, wdata_i;
  logic [1:0][3:0]   be_i;
  logic [31:0]       rdata_o, mgr_addr_o, mgr_wdata_o, mgr_rdata_i = 0;
  logic [3:0]        mgr_be_o;
  logic              err_o, mgr_req_o, mgr_gnt_i = 0, mgr_we_o, mgr_rvalid_i = 0, mgr_err_i = 0;
  logic              idle_o, rsp_err_o;
  int                checks = 0, failures = 0;

  user_mgr_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .err_o(err_o), .mgr_req_o(mgr_req_o), .mgr_gnt_i(mgr_gnt_i), .mgr_addr_o(mgr_addr_o),
    .mgr_we_o(mgr_we_o), .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o),
    .mgr_rvalid_i(mgr_rvalid_i), .mgr_rdata_i(mgr_rdata_i), .mgr_err_i(mgr_err_i),
    .idle_o(idle_o), .rsp_err_o(rsp_err_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv);
    req_i = req;
    mgr_gnt_i = gnt;
    mgr_rvalid_i = rv;
    #1;
  endtask

  initial begin
    addr_i[0] = 32'h100; addr_i[1] = 32'h200;
    wdata_i[0] = 32'hAAAA; wdata_i[1] = 32'hBBBB;
    be_i[0] = 4'h3; be_i[1] = 4'hC;
    drive(2'b11, 1, 1);
    chk("rst_mgr_req", mgr_req_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    tick();
    rst_i = 0;
    drive(2'b00, 0, 0);
    chk("idle_after_rst", idle_o, 1);
    chk("rsp_err_after_rst", rsp_err_o, 0);
    // continuous alternation
    drive(2'b11, 1, 0);
    chk("rr_g0", gnt_o, 2'b01);
    chk("rr_addr0", mgr_addr_o, 32'h100);
    chk("rr_wdata0", mgr_wdata_o, 32'hAAAA);
    tick();
    mgr_rdata_i = 32'hDEAD;
    drive(2'b11, 1, 1);
    chk("rr_g1", gnt_o, 2'b10);
    chk("rr_be1", mgr_be_o, 4'hC);
    chk("rr_rv0", rvalid_o, 2'b01);
    chk("rdata_pass", rdata_o, 32'hDEAD);
    tick();
    drive(2'b11, 1, 1);
    chk("rr_g2", gnt_o, 2'b01);
    chk("rr_rv1", rvalid_o, 2'b10);
    tick();
    drive(2'b11, 1, 1);
    chk("rr_g3", gnt_o, 2'b10);
    chk("rr_rv2", rvalid_o, 2'b01);
    tick();
    drive(2'b00, 0, 1);
    chk("rr_rv3", rvalid_o, 2'b10);
    tick();
    drive(2'b00, 0, 0);
    chk("idle_drained", idle_o, 1);
    // single grant of req0 moves priority to req1
    drive(2'b01, 1, 0);
    chk("single_g0", gnt_o, 2'b01);
    tick();
    // stall req0; req1 (now higher priority) rises but selection stays locked
    drive(2'b01, 0, 1);
    chk("stall_rv", rvalid_o, 2'b01);
    chk("stall_req", mgr_req_o, 1);
    chk("stall_addr0", mgr_addr_o, 32'h100);
    tick();
    drive(2'b11, 0, 0);
    chk("lock_addr1", mgr_addr_o, 32'h100);
    chk("lock_gnt1", gnt_o, 2'b00);
    tick();
    drive(2'b11, 0, 0);
    chk("lock_addr2", mgr_addr_o, 32'h100);
    tick();
    drive(2'b11, 1, 0);
    chk("lock_release_gnt", gnt_o, 2'b01);
    chk("lock_release_addr", mgr_addr_o, 32'h100);
    tick();
    drive(2'b11, 1, 0);
    chk("after_lock_gnt", gnt_o, 2'b10);
    chk("after_lock_addr", mgr_addr_o, 32'h200);
    tick();
    // FIFO full: forwarding blocked, same-cycle pop does not unblock
    drive(2'b11, 1, 0);
    chk("full_req", mgr_req_o, 0);
    chk("full_gnt", gnt_o, 2'b00);
    chk("full_idle", idle_o, 0);
    tick();
    drive(2'b11, 1, 1);
    chk("full_pop_req", mgr_req_o, 0);
    chk("full_pop_rv", rvalid_o, 2'b01);
    tick();
    drive(2'b11, 1, 0);
    chk("resume_gnt", gnt_o, 2'b01);
    tick();
    // reset with two outstanding entries
    rst_i = 1;
    drive(2'b11, 1, 0);
    chk("midrst_req", mgr_req_o, 0);
    chk("midrst_gnt", gnt_o, 0);
    tick();
    rst_i = 0;
    drive(2'b00, 0, 0);
    chk("postrst_idle", idle_o, 1);
    drive(2'b11, 1, 0);
    chk("postrst_g0", gnt_o, 2'b01);
    tick();
    drive(2'b00, 0, 1);
    chk("postrst_rv", rvalid_o, 2'b01);
    tick();
    // stray response with empty FIFO
    drive(2'b00, 0, 1);
    chk("stray_rv", rvalid_o, 2'b00);
    tick();
    drive(2'b00, 0, 0);
    chk("stray_err", rsp_err_o, 1);
    tick();
    chk("stray_err_held", rsp_err_o, 1);
    rst_i = 1;
    #1;
    chk("stray_err_cleared", rsp_err_o, 0);
    tick();
    rst_i = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/user_mgr_arbiter.md
USER_MGR_ARBITER -- requirements
Module: user_mgr_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2, number of OBI manager requesters sharing the user manager port.
REQ-002 SHALL have parameter MaxTrans, default 2, maximum outstanding granted transactions (response-tracking FIFO depth).
REQ-003 SHALL have parameters AddrWidth, default 32, and DataWidth, default 32, for the address and data bus widths.
REQ-004 Port: clk_i, input, 1, single clock; all logic is rising-edge.
REQ-005 Port: rst_i, input, 1, asynchronous active-high reset.
REQ-006 Port: req_i / gnt_o, input / output, NumReq each, per-requester OBI A-channel request and grant.
REQ-007 Port: addr_i / we_i / be_i / wdata_i, input, NumReq x (AddrWidth / 1 / DataWidth/8 / DataWidth), per-requester A-channel payload.
REQ-008 Port: rvalid_o / rdata_o / err_o, output, NumReq / DataWidth / 1, per-requester R-channel; rdata_o and err_o are shared by all requesters.
REQ-009 Port: mgr_req_o / mgr_gnt_i, output / input, 1 each, downstream OBI A-channel handshake.
REQ-010 Port: mgr_addr_o / mgr_we_o / mgr_be_o / mgr_wdata_o, output, AddrWidth / 1 / DataWidth/8 / DataWidth, downstream A-channel payload.
REQ-011 Port: mgr_rvalid_i / mgr_rdata_i / mgr_err_i, input, 1 / DataWidth / 1, downstream R-channel.
REQ-012 Port: idle_o, output, 1, high when there is no pending request and no outstanding transaction.
REQ-013 Port: rsp_err_o, output, 1, sticky flag set when a response arrives with no outstanding transaction.

Function
REQ-014 SHALL select one requester per A-channel transfer using round-robin arbitration; the index after the last granted one has highest priority; after reset index 0 has highest priority.
REQ-015 SHALL lock the selection while mgr_req_o=1 and mgr_gnt_i=0, so the downstream payload is stable until grant (OBI rule), even if a higher-priority req_i rises.
REQ-016 SHALL drive mgr_req_o combinationally from the selected req_i when not blocked, and mux the selected payload onto mgr_* outputs.
REQ-017 SHALL assert gnt_o[k] = mgr_gnt_i AND mgr_req_o AND selected==k, with zero-cycle grant latency (combinational pass-through).
REQ-018 SHALL push the selected index into the tracking FIFO on each downstream handshake (mgr_req_o AND mgr_gnt_i).
REQ-019 SHALL block forwarding when the FIFO holds MaxTrans entries: mgr_req_o=0, all gnt_o=0; a same-cycle pop does not unblock that cycle.
REQ-020 SHALL route mgr_rvalid_i to rvalid_o[head index], pass mgr_rdata_i/mgr_err_i to rdata_o/err_o, and pop the FIFO in the same cycle (zero-cycle response latency).
REQ-021 SHALL support simultaneous push and pop when the FIFO is not full; occupancy is unchanged and order is preserved.
REQ-022 SHALL drop mgr_rvalid_i received while the FIFO is empty (all rvalid_o=0) and set rsp_err_o until reset.
REQ-023 SHALL keep responses in order; FIFO pointers wrap modulo MaxTrans; the occupancy counter spans 0..MaxTrans.
REQ-024 SHALL advance the round-robin pointer only on a downstream handshake.
REQ-025 SHALL require NumReq>=2 and MaxTrans>=1; elaboration SHALL fail otherwise.

Reset
REQ-026 SHALL, while rst_i=1, force FIFO empty, priority pointer 0, lock cleared, rsp_err_o=0, and mgr_req_o=0, gnt_o=0 and rvalid_o=0 regardless of inputs.
REQ-027 SHALL, on reset asserted mid-transaction, discard outstanding entries; responses arriving after release with the FIFO empty follow REQ-022.
REQ-028 idle_o SHALL be 1 after reset release when no req_i is set.

Verification
REQ-029 Both requesters request continuously, mgr_gnt_i=1, responses returned each next cycle -> grants alternate 0,1,0,1, and each rvalid_o matches its grant order.
REQ-030 Req0 is stalled (mgr_gnt_i=0 for 3 cycles) and req1 rises meanwhile -> mgr_addr_o stays req0's address until grant; req1 is granted next.
REQ-031 MaxTrans=2, two grants, no responses -> third request sees mgr_req_o=0; after one rvalid, forwarding resumes the next cycle.
REQ-032 FIFO at 1 entry, push and pop in the same cycle -> occupancy stays 1; the response goes to the older index.
REQ-033 mgr_rvalid_i pulse with the FIFO empty -> no rvalid_o, rsp_err_o=1 held until rst_i.
REQ-034 rst_i asserted with 2 outstanding entries -> after release idle_o=1, the pointer is 0, and req0 wins a simultaneous request.
